// File: rtl/protobuf_pkg.sv
// Shared constants, state types and varint helper for the protobuf deserializer.
package protobuf_pkg;

    localparam logic [7:0] PB_ADDR_DATA   = 8'h00;
    localparam logic [7:0] PB_ADDR_STATUS = 8'h04;

    localparam int unsigned PB_VARINT_MAX_BYTES = 5;

    // STATUS register bit positions
    localparam int unsigned PB_ST_OVF      = 0;
    localparam int unsigned PB_ST_TRUNC    = 1;
    localparam int unsigned PB_ST_PEND     = 2;
    localparam int unsigned PB_ST_OCNT_LSB = 8;
    localparam int unsigned PB_ST_ICNT_LSB = 12;

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} dec_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

    // Payload bits of varint byte n placed at their final position; the last
    // byte only carries 4 useful bits of a 32-bit value.
    function automatic logic [31:0] pb_varint_bits(input logic [7:0] b, input logic [2:0] n);
        logic [31:0] v;
        v = {25'd0, b[6:0]};
        if (32'(n) == PB_VARINT_MAX_BYTES - 1) v = {28'd0, b[3:0]};
        return v << (7 * 32'(n));
    endfunction

endpackage

// File: rtl/pb_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read and up to LANES pushes per
// cycle. The caller guarantees room for push_n entries.
module pb_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LANES = 1,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1,
    localparam int unsigned NW = $clog2(LANES + 1)
) (
    input  logic                         clock_clk,
    input  logic                         reset_reset_n,
    input  logic [NW-1:0]                push_n,
    input  logic [LANES-1:0][WIDTH-1:0]  push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [CW-1:0]                count,
    output logic                         full,
    output logic                         empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers and occupancy; simultaneous push and pop net out in the count.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + CW'(push_n) - CW'(pop_ok);
        end
    end

    // Storage, written in lane order starting at the write pointer.
    always_ff @(posedge clock_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (NW'(i) < push_n) mem[wr_ptr + AW'(i)] <= push_data[i];
        end
    end

endmodule

// File: rtl/protobuf_deserializer.sv
// AXI4 slave: raw varint bytes in on the write channels, decoded 32-bit words
// out on FIXED-burst reads, plus a STATUS register with sticky error bits.
module protobuf_deserializer
    import protobuf_pkg::*;
#(
    parameter int unsigned IN_DEPTH  = 16,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic        clock_clk,
    input  logic        reset_reset_n,
    input  logic [3:0]  axs_s0_awid,
    input  logic [15:0] axs_s0_awaddr,
    input  logic [7:0]  axs_s0_awlen,
    input  logic [2:0]  axs_s0_awsize,
    input  logic [1:0]  axs_s0_awburst,
    input  logic        axs_s0_awvalid,
    output logic        axs_s0_awready,
    input  logic [31:0] axs_s0_wdata,
    input  logic [3:0]  axs_s0_wstrb,
    input  logic        axs_s0_wvalid,
    output logic        axs_s0_wready,
    output logic [3:0]  axs_s0_bid,
    output logic        axs_s0_bvalid,
    input  logic        axs_s0_bready,
    input  logic [3:0]  axs_s0_arid,
    input  logic [15:0] axs_s0_araddr,
    input  logic [7:0]  axs_s0_arlen,
    input  logic [2:0]  axs_s0_arsize,
    input  logic [1:0]  axs_s0_arburst,
    input  logic        axs_s0_arvalid,
    output logic        axs_s0_arready,
    output logic [3:0]  axs_s0_rid,
    output logic [31:0] axs_s0_rdata,
    output logic        axs_s0_rlast,
    output logic        axs_s0_rvalid,
    input  logic        axs_s0_rready
);

    localparam int unsigned IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int unsigned OUT_CW = $clog2(OUT_DEPTH) + 1;

    wr_state_t        wr_state;
    rd_state_t        rd_state;
    dec_state_t       dec_state, dec_state_d;

    logic [3:0][8:0]  in_push_data;
    logic [2:0]       in_push_n;
    logic [8:0]       in_pop_data;
    logic [IN_CW-1:0] in_count;
    logic             in_empty, in_full_unused;
    logic [31:0]      out_pop_data;
    logic [OUT_CW-1:0] out_count;
    logic             out_empty, out_full;

    logic             wr_ack, eom_now;
    logic             dec_pop, dec_push, set_ovf, set_trunc;
    logic [31:0]      acc_q, acc_d, acc_sum;
    logic [2:0]       n_q, n_d;
    logic             ovf_q, trunc_q;
    logic [31:0]      status;
    logic             status_clr;

    logic [7:0]       rd_addr;
    logic [8:0]       beats_left;
    logic             rd_is_data, rd_next, rd_issue, rd_pop;
    logic [31:0]      beat_data;
    logic             unused_inputs;

    assign unused_inputs = ^{axs_s0_awaddr[15:1], axs_s0_awlen, axs_s0_awsize, axs_s0_awburst,
                             axs_s0_araddr[15:8], axs_s0_arsize, axs_s0_arburst, in_full_unused};

    assign wr_ack  = (wr_state == WR_ACK);
    // A strobe-less EOM write has no byte to carry the flag, so it acts at once.
    assign eom_now = wr_ack && (axs_s0_wstrb == 4'b0000) && axs_s0_awaddr[0];

    // Write FSM: registered ready pulse, then hold the response until bready.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            wr_state       <= WR_IDLE;
            axs_s0_awready <= 1'b0;
            axs_s0_wready  <= 1'b0;
            axs_s0_bvalid  <= 1'b0;
            axs_s0_bid     <= '0;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (axs_s0_awvalid && axs_s0_wvalid && !axs_s0_bvalid &&
                        in_count <= IN_CW'(IN_DEPTH - 4)) begin
                        axs_s0_awready <= 1'b1;
                        axs_s0_wready  <= 1'b1;
                        wr_state       <= WR_ACK;
                    end
                end
                WR_ACK: begin
                    axs_s0_awready <= 1'b0;
                    axs_s0_wready  <= 1'b0;
                    axs_s0_bvalid  <= 1'b1;
                    axs_s0_bid     <= axs_s0_awid;
                    wr_state       <= WR_RESP;
                end
                WR_RESP: begin
                    if (axs_s0_bready) begin
                        axs_s0_bvalid <= 1'b0;
                        wr_state      <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Compact strobed lanes in ascending order; EOM rides on the last one.
    always_comb begin
        logic [2:0] cnt;
        logic [2:0] last;
        in_push_data = '0;
        cnt          = '0;
        for (int i = 0; i < 4; i++) begin
            if (axs_s0_wstrb[i]) begin
                in_push_data[cnt[1:0]] = {1'b0, axs_s0_wdata[8*i +: 8]};
                cnt = cnt + 3'd1;
            end
        end
        last = cnt - 3'd1;
        if (cnt != 3'd0) in_push_data[last[1:0]][8] = axs_s0_awaddr[0];
        in_push_n = wr_ack ? cnt : 3'd0;
    end

    pb_sync_fifo #(
        .WIDTH (9),
        .DEPTH (IN_DEPTH),
        .LANES (4)
    ) u_in_fifo (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .push_n        (in_push_n),
        .push_data     (in_push_data),
        .pop           (dec_pop),
        .pop_data      (in_pop_data),
        .count         (in_count),
        .full          (in_full_unused),
        .empty         (in_empty)
    );

    // Decoder next state: one byte per cycle, word pushed on the terminator.
    always_comb begin
        dec_state_d = dec_state;
        acc_d       = acc_q;
        n_d         = n_q;
        set_ovf     = 1'b0;
        set_trunc   = 1'b0;
        dec_push    = 1'b0;
        dec_pop     = !in_empty && !out_full;
        acc_sum     = acc_q | pb_varint_bits(in_pop_data[7:0], n_q);
        if (dec_pop) begin
            if (dec_state == DISCARD) begin
                if (!in_pop_data[7]) begin
                    dec_state_d = IDLE;
                end else if (in_pop_data[8]) begin
                    set_trunc   = 1'b1;
                    dec_state_d = IDLE;
                end
            end else if (!in_pop_data[7]) begin
                dec_push    = 1'b1;
                acc_d       = '0;
                n_d         = '0;
                dec_state_d = IDLE;
            end else if (32'(n_q) == PB_VARINT_MAX_BYTES - 1) begin
                set_ovf     = 1'b1;
                set_trunc   = in_pop_data[8];
                acc_d       = '0;
                n_d         = '0;
                dec_state_d = in_pop_data[8] ? IDLE : DISCARD;
            end else if (in_pop_data[8]) begin
                set_trunc   = 1'b1;
                acc_d       = '0;
                n_d         = '0;
                dec_state_d = IDLE;
            end else begin
                acc_d       = acc_sum;
                n_d         = n_q + 3'd1;
                dec_state_d = ACCUM;
            end
        end
        if (eom_now && dec_state_d == ACCUM) begin
            set_trunc   = 1'b1;
            acc_d       = '0;
            n_d         = '0;
            dec_state_d = IDLE;
        end
    end

    // Decoder state and sticky errors; a new error wins over a STATUS clear.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            dec_state <= IDLE;
            acc_q     <= '0;
            n_q       <= '0;
            ovf_q     <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            dec_state <= dec_state_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            ovf_q     <= (ovf_q && !status_clr) || set_ovf;
            trunc_q   <= (trunc_q && !status_clr) || set_trunc;
        end
    end

    pb_sync_fifo #(
        .WIDTH (32),
        .DEPTH (OUT_DEPTH),
        .LANES (1)
    ) u_out_fifo (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .push_n        (dec_push),
        .push_data     (acc_sum),
        .pop           (rd_pop),
        .pop_data      (out_pop_data),
        .count         (out_count),
        .full          (out_full),
        .empty         (out_empty)
    );

    // STATUS register image.
    always_comb begin
        status                        = '0;
        status[PB_ST_OVF]             = ovf_q;
        status[PB_ST_TRUNC]           = trunc_q;
        status[PB_ST_PEND]            = (dec_state != IDLE);
        status[PB_ST_OCNT_LSB +: 4]   = 4'(out_count);
        status[PB_ST_ICNT_LSB +: 4]   = 4'(in_count);
    end

    assign rd_is_data = (rd_addr == PB_ADDR_DATA);
    assign rd_next    = (rd_state == RD_BURST) && (beats_left != '0) &&
                        (!axs_s0_rvalid || axs_s0_rready);
    assign rd_issue   = rd_next && (!rd_is_data || !out_empty);
    assign rd_pop     = rd_issue && rd_is_data;
    assign status_clr = (rd_state == RD_BURST) && axs_s0_rvalid && axs_s0_rready &&
                        (rd_addr == PB_ADDR_STATUS);
    assign beat_data  = rd_is_data ? out_pop_data :
                        (rd_addr == PB_ADDR_STATUS) ? status : 32'd0;

    // Read FSM: capture AR, then present beats with registered R outputs.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            rd_state       <= RD_IDLE;
            axs_s0_arready <= 1'b0;
            axs_s0_rvalid  <= 1'b0;
            axs_s0_rlast   <= 1'b0;
            axs_s0_rdata   <= '0;
            axs_s0_rid     <= '0;
            rd_addr        <= '0;
            beats_left     <= '0;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (axs_s0_arready && axs_s0_arvalid) begin
                        axs_s0_arready <= 1'b0;
                        axs_s0_rid     <= axs_s0_arid;
                        rd_addr        <= axs_s0_araddr[7:0];
                        beats_left     <= (axs_s0_araddr[7:0] == PB_ADDR_STATUS) ? 9'd1 :
                                          9'(axs_s0_arlen) + 9'd1;
                        rd_state       <= RD_BURST;
                    end else begin
                        axs_s0_arready <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (rd_issue) begin
                        axs_s0_rvalid <= 1'b1;
                        axs_s0_rdata  <= beat_data;
                        axs_s0_rlast  <= (beats_left == 9'd1);
                        beats_left    <= beats_left - 9'd1;
                    end else if (axs_s0_rvalid && axs_s0_rready) begin
                        axs_s0_rvalid <= 1'b0;
                        axs_s0_rlast  <= 1'b0;
                        if (axs_s0_rlast) begin
                            rd_state       <= RD_IDLE;
                            axs_s0_arready <= 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_protobuf_deserializer.sv
// Scoreboard bench: stimulus pushes expected R beats, a monitor checks them.
module tb_protobuf_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid, arid, bid, rid;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    // Reference model state: bytes of the varint in progress, decoded words.
    logic [7:0]  m_cur[$];
    logic [31:0] m_words[$];
    bit          m_disc, m_ovf, m_trunc;

    always #5 clk = ~clk;

    protobuf_deserializer dut (
        .clock_clk      (clk),
        .reset_reset_n  (rst_n),
        .axs_s0_awid    (awid),
        .axs_s0_awaddr  (awaddr),
        .axs_s0_awlen   (awlen),
        .axs_s0_awsize  (awsize),
        .axs_s0_awburst (awburst),
        .axs_s0_awvalid (awvalid),
        .axs_s0_awready (awready),
        .axs_s0_wdata   (wdata),
        .axs_s0_wstrb   (wstrb),
        .axs_s0_wvalid  (wvalid),
        .axs_s0_wready  (wready),
        .axs_s0_bid     (bid),
        .axs_s0_bvalid  (bvalid),
        .axs_s0_bready  (bready),
        .axs_s0_arid    (arid),
        .axs_s0_araddr  (araddr),
        .axs_s0_arlen   (arlen),
        .axs_s0_arsize  (arsize),
        .axs_s0_arburst (arburst),
        .axs_s0_arvalid (arvalid),
        .axs_s0_arready (arready),
        .axs_s0_rid     (rid),
        .axs_s0_rdata   (rdata),
        .axs_s0_rlast   (rlast),
        .axs_s0_rvalid  (rvalid),
        .axs_s0_rready  (rready)
    );

    // Value = sum of 7-bit groups weighted by 128^i, reduced mod 2^32.
    function automatic void mdl_byte(input logic [7:0] b, input bit eom);
        logic [31:0] v;
        if (m_disc) begin
            if (!b[7]) m_disc = 0;
            else if (eom) begin m_trunc = 1; m_disc = 0; end
            return;
        end
        m_cur.push_back(b);
        if (!b[7]) begin
            v = 0;
            foreach (m_cur[i]) v = v + ({25'd0, m_cur[i][6:0]} << (7 * i));
            m_words.push_back(v);
            m_cur.delete();
        end else if (m_cur.size() == 5) begin
            m_ovf = 1;
            m_cur.delete();
            if (eom) m_trunc = 1; else m_disc = 1;
        end else if (eom) begin
            m_trunc = 1;
            m_cur.delete();
        end
    endfunction

    function automatic logic [31:0] mdl_status();
        return {16'h0, 4'h0, 4'(m_words.size()), 5'h0,
                (m_cur.size() != 0 || m_disc), m_trunc, m_ovf};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: randomise rready, check hold stability and scoreboard beats.
    initial begin
        bit hold = 0;
        beat_t h, e;
        rready = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold   = 0;
                rready = 0;
            end else begin
                if (hold) begin
                    checks++;
                    if (!(rvalid && rdata == h.data && rid == h.id && rlast == h.last)) begin
                        errors++;
                        $display("FAIL r_stable actual=%0b/%0h/%0h/%0b required=1/%0h/%0h/%0b",
                                 rvalid, rdata, rid, rlast, h.data, h.id, h.last);
                    end
                end
                rready = ($urandom_range(0, 3) != 0);
                if (rvalid && rready) begin
                    hold = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL r_unexpected actual=%0h/%0h/%0b required=no beat",
                                 rdata, rid, rlast);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rdata, rid, rlast} !== {e.data, e.id, e.last}) begin
                            errors++;
                            $display("FAIL r_beat actual=%0h/%0h/%0b required=%0h/%0h/%0b",
                                     rdata, rid, rlast, e.data, e.id, e.last);
                        end
                    end
                end else begin
                    hold = rvalid;
                    h    = '{data: rdata, id: rid, last: rlast};
                end
            end
        end
    end

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id);
        bit ok = 0;
        int last_lane = -1;
        @(negedge clk);
        awaddr = addr; awid = id; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1;
        for (int n = 0; n < 300; n++) begin
            if (awready && wready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("aw_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        if (ok) begin
            for (int i = 0; i < 4; i++) if (strb[i]) last_lane = i;
            for (int i = 0; i < 4; i++)
                if (strb[i]) mdl_byte(data[8*i +: 8], addr[0] && i == last_lane);
        end
        bready = 1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
        end
        check("b_resp", {59'd0, ok, bid}, {59'd1, id});
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len);
        bit ok = 0;
        @(negedge clk);
        arid = id; araddr = {8'h00, addr}; arlen = len; arvalid = 1;
        for (int n = 0; n < 100; n++) begin
            if (arready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("ar_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic wait_empty();
        bit ok = 0;
        for (int n = 0; n < 1000; n++) begin
            if (exp_q.size() == 0) begin ok = 1; break; end
            @(negedge clk);
        end
        check("r_timeout", 64'(ok), 64'd1);
        exp_q.delete();
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len);
        if (addr == 8'h00) begin
            for (int i = 0; i <= int'(len); i++)
                exp_q.push_back('{data: m_words.pop_front(), id: id, last: (i == int'(len))});
        end else if (addr == 8'h04) begin
            exp_q.push_back('{data: mdl_status(), id: id, last: 1'b1});
            m_ovf = 0; m_trunc = 0;
        end else begin
            for (int i = 0; i <= int'(len); i++)
                exp_q.push_back('{data: 32'd0, id: id, last: (i == int'(len))});
        end
        issue_ar(id, addr, len);
        wait_empty();
    endtask

    task automatic drain();
        repeat (60) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {awready, wready, bvalid, arready, rvalid, rlast, bid, rid, rdata},
              64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  bytes[$];
        logic [31:0] v, data;
        logic [3:0]  strb, mask;
        int          k, rem, len, bad;

        rst_n = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 0; arvalid = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk); rst_n = 1;

        // 150 in two bytes
        axi_write(16'h0000, 32'h0000_0196, 4'b0011, 4'h1);
        drain();
        axi_read(4'h3, 8'h00, 8'd0);

        // 8, 300, 127 in one beat
        axi_write(16'h0000, 32'h7F02_AC08, 4'b1111, 4'h2);
        drain();
        axi_read(4'h7, 8'h00, 8'd2);

        // Five-byte maximum values, with and without high bits in byte 5
        axi_write(16'h0000, 32'hFFFF_FFFF, 4'b1111, 4'h4);
        axi_write(16'h0000, 32'h0000_000F, 4'b0001, 4'h5);
        axi_write(16'h0000, 32'hFFFF_FFFF, 4'b1111, 4'h4);
        axi_write(16'h0000, 32'h0000_007F, 4'b0001, 4'h5);
        drain();
        axi_read(4'hA, 8'h00, 8'd1);

        // Overflow, discard through terminator, then 5
        axi_write(16'h0000, 32'h8080_8080, 4'b1111, 4'h6);
        axi_write(16'h0000, 32'h0501_8080, 4'b1111, 4'h6);
        drain();
        axi_read(4'h1, 8'h04, 8'd5);
        axi_read(4'h2, 8'h00, 8'd0);
        axi_read(4'h3, 8'h04, 8'd0);

        // Truncated varint via EOM
        axi_write(16'h00F1, 32'h0000_0080, 4'b0001, 4'h8);
        drain();
        axi_read(4'h4, 8'h04, 8'd0);
        axi_read(4'h5, 8'h04, 8'd0);

        // Unmapped address returns zeros
        axi_read(4'h6, 8'h10, 8'd1);

        // Short burst stalls, then reset abandons it
        axi_write(16'h0000, 32'h0000_0005, 4'b0001, 4'h9);
        drain();
        exp_q.push_back('{data: m_words.pop_front(), id: 4'hC, last: 1'b0});
        issue_ar(4'hC, 8'h00, 8'd3);
        wait_empty();
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid) bad++;
        end
        check("r_stall_low", 64'(bad), 64'd0);
        @(negedge clk); rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_burst");
        @(negedge clk); rst_n = 1;
        m_cur.delete(); m_words.delete(); m_disc = 0; m_ovf = 0; m_trunc = 0;
        repeat (3) @(negedge clk);
        axi_read(4'hD, 8'h04, 8'd0);
        axi_write(16'h0000, 32'h0000_002A, 4'b0001, 4'hE);
        drain();
        axi_read(4'hF, 8'h00, 8'd0);

        // Random varint streams with random strobe packing
        for (int r = 0; r < 10; r++) begin
            k = $urandom_range(1, 5);
            for (int w = 0; w < k; w++) begin
                v = $urandom() >> $urandom_range(0, 31);
                do begin
                    data[7:0] = {1'b0, v[6:0]};
                    v = v >> 7;
                    if (v != 0) data[7] = 1'b1;
                    bytes.push_back(data[7:0]);
                end while (v != 0);
            end
            while (bytes.size() > 0) begin
                strb = 4'($urandom_range(1, 15));
                data = $urandom();
                mask = 0;
                for (int i = 0; i < 4; i++) begin
                    if (strb[i] && bytes.size() > 0) begin
                        data[8*i +: 8] = bytes.pop_front();
                        mask[i] = 1;
                    end
                end
                axi_write({15'd0, (bytes.size() == 0) && r[0]}, data, mask,
                          4'($urandom_range(0, 15)));
            end
            drain();
            if (r[1]) axi_read(4'($urandom_range(0, 15)), 8'h04, 8'($urandom_range(0, 3)));
            rem = k;
            while (rem > 0) begin
                len = $urandom_range(0, rem - 1);
                axi_read(4'($urandom_range(0, 15)), 8'h00, 8'(len));
                rem -= len + 1;
            end
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/protobuf_deserializer.md
# protobuf_deserializer

AXI4 slave that decodes a protobuf varint byte stream back into 32-bit values, the receive-side counterpart of `protobuf_serializer`. Software or DMA writes raw serialized bytes on the write channels. The block strips base-128 varint framing and queues the decoded words. A master drains them with FIXED-burst reads. It sits beside the serializer on the same Qsys interconnect.

## Interface
- `IN_DEPTH`, 16: input byte FIFO depth in bytes, power of two, at least 4.
- `OUT_DEPTH`, 8: decoded word FIFO depth, power of two.
- `clock_clk`  in  1  sole clock; all logic is rising-edge.
- `reset_reset_n`  in  1  reset, synchronous and active-low.
- `axs_s0_awid`/`awaddr`/`awlen`/`awsize`/`awburst`  in  4/16/8/3/2  write address channel.
- `axs_s0_awvalid` in 1, `axs_s0_awready` out 1.
- `axs_s0_wdata`  in  32, `axs_s0_wstrb`  in  4, `axs_s0_wvalid` in 1, `axs_s0_wready` out 1.
- `axs_s0_bid`  out  4, `axs_s0_bvalid` out 1, `axs_s0_bready` in 1.
- `axs_s0_arid`/`araddr`/`arlen`/`arsize`/`arburst`  in  4/16/8/3/2  read address channel.
- `axs_s0_arvalid` in 1, `axs_s0_arready` out 1.
- `axs_s0_rid` out 4, `axs_s0_rdata` out 32, `axs_s0_rlast` out 1, `axs_s0_rvalid` out 1, `axs_s0_rready` in 1.
- Reset values: all ready, valid and last outputs 0; `bid`, `rid` and `rdata` 0.

## Operation
- **Write.** Only single-beat writes are used; `awlen`, `awsize` and `awburst` are ignored.
  - Accept when `awvalid & wvalid & !bvalid` and the input FIFO has at least 4 free bytes.
  - On accept, `awready` and `wready` pulse together for one cycle.
  - Each byte lane whose `wstrb` bit is set is pushed in ascending lane order (lane 0 first); unstrobed lanes are dropped.
  - `awaddr[0]` is the end-of-message flag (EOM).
  - The EOM flag is stored alongside the last pushed byte. With `wstrb`=0000 the flag applies immediately.
- **Response.** `bvalid` rises the cycle after accept, with `bid` equal to the captured `awid`. It holds until `bready`. The response is always OKAY.
- **Decoder.**
  - Pops one byte per cycle while the input FIFO is non-empty and the output FIFO is not full.
  - For byte index n (0 to 4): `acc |= byte[6:0] << 7n`. On the 5th byte only bits [3:0] are kept and bits [6:4] are discarded.
  - `byte[7]`=0 terminates the value: `acc` is pushed to the output FIFO, then `acc` and n are cleared.
  - Overflow: a 5th byte with `byte[7]`=1 sets sticky `err_ovf` and enters DISCARD state. DISCARD drops bytes through the next terminator, pushes nothing, then returns to IDLE.
  - EOM on a byte with `byte[7]`=1 (truncated varint) sets sticky `err_trunc` and clears `acc` and n.
- **Read.**
  - `arready` is high only while the read side is idle. The block captures `arid`, `arlen` and `araddr[7:0]`.
  - Address 0x00 (DATA): `arlen`+1 beats. Each beat pops one word, and `rvalid` stays low while the output FIFO is empty. `rlast` is set on the final beat.
  - Address 0x04 (STATUS): exactly one beat regardless of `arlen`, with `rlast`=1.
    - STATUS fields: bit0 `err_ovf`, bit1 `err_trunc`, bit2 partial varint pending, bits[11:8] output FIFO count, bits[15:12] input FIFO count.
    - The beat returns the pre-clear value and clears both error bits on handshake.
  - Any other address returns 0 for `arlen`+1 beats.

## Timing
- Write-to-data latency: a write is accepted at T. Bytes are poppable at T+1, and `bvalid` is 1 from T+1.
- Decode latency: a terminator byte popped at cycle P makes its word visible in the output FIFO at P+1.
- Read latency: the AR handshake is at cycle A.
  - The first `rvalid` is no earlier than A+1.
  - After each `rvalid & rready` the next beat can be valid the following cycle, giving 1 word per cycle throughput.
  - `rdata`, `rid` and `rlast` stay stable while `rvalid & !rready`.
- A new AR is accepted no earlier than the cycle after the last-beat handshake.
- Simultaneous pop and push on either FIFO in the same cycle is legal and leaves the count unchanged.
- Full output FIFO: the decoder stalls and holds `acc` and n.
- Reset mid-burst: `reset_reset_n`=0 sampled at an edge returns every output to its reset value. It also empties both FIFOs and clears the decoder state and error bits. An in-flight burst is abandoned with no `rlast`.

## Structure
- Package `protobuf_pkg` holds:
  - address constants `PB_ADDR_DATA`=0x00, `PB_ADDR_STATUS`=0x04;
  - `PB_VARINT_MAX_BYTES`=5;
  - STATUS bit-position constants;
  - decoder state enum IDLE/ACCUM/DISCARD.
- One sub-module, `pb_sync_fifo`, parameterised on WIDTH and DEPTH and instantiated twice:
  - input FIFO: 9-bit entries (8 data bits + EOM flag);
  - output FIFO: 32-bit entries.
  - It provides count, full and empty, with `reset_reset_n` synchronous clear.
- The top level holds the write FSM, read FSM and decoder.

## Test plan
- Write bytes 0x96 0x01 (`wstrb`=0011), then read DATA with `arlen`=0. Expected: `rdata`=0x00000096 (150), `rlast`=1, `rid` equals `arid`.
- Write bytes 0x08, 0xAC 0x02, 0x7F in one beat (`wdata`=0x7F02AC08, `wstrb`=1111), then read with `arlen`=2. Expected: 8, 300, 127 with `rlast` only on beat 3.
- Write bytes 0xFF 0xFF 0xFF 0xFF 0x0F across two beats. Expected: 0xFFFFFFFF.
  - Variant: 0xFF ×4 then 0x7F. Expected: 0xFFFFFFFF, since bits [6:4] of the 5th byte are discarded.
- Write 0x80 ×5, 0x80, 0x01, 0x05. Expected:
  - STATUS reads 0x...01 (`err_ovf` set);
  - DATA returns only 5;
  - a second STATUS read shows bit0=0.
- Write 0x80 with `awaddr`=0xF1 (EOM). Expected: STATUS bit1=1 and bit2=0, and no word queued.
- Issue a DATA read with `arlen`=3 with only 1 word available. Expected: 1 beat completes and `rvalid` then stays low. Assert reset for 2 cycles. Expected: `rvalid`=0, STATUS count=0, and a subsequent write of 0x2A reads back 42.
